// File: rtl/sync_debounce.sv
// sync_debounce: per-bit multi-flop synchroniser followed by a debounce filter.
// Define SYNC_DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs.
module sync_debounce #(
   parameter int WIDTH = 1,
   parameter int STAGES = 2,
   parameter int DEBOUNCE = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   logic [WIDTH-1:0] chain [STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] q_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) chain[s] <= RST_VAL;
      end else begin
         chain[0] <= d_in;
         for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
      end
   assign sync = chain[STAGES-1];
   generate
      if (DEBOUNCE == 0) begin : g_direct
         // q_next is the value q_out will hold after the coming edge
         assign q_out  = sync;
         assign q_next = chain[STAGES-2];
      end else begin : g_filter
         localparam int CW = $clog2(DEBOUNCE + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt;
            logic          differ;
            assign differ    = sync[i] != q_out[i];
            assign q_next[i] = (differ && cnt == LAST) ? sync[i] : q_out[i];
            always_ff @(posedge clk or negedge rst_n)
               if (!rst_n) cnt <= '0;
               else cnt <= (!differ || cnt == LAST) ? '0 : cnt + CW'(1);
         end
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) q_out <= RST_VAL;
            else q_out <= q_next;
      end
   endgenerate
`ifdef SYNC_DEBOUNCE_EDGE_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= q_next & ~q_out;
         fall <= ~q_next & q_out;
      end
`else
   assign rise = '0;
   assign fall = '0;
`endif
endmodule
